// File: rtl/ldst_control_sequencer.sv
// ldst_control_sequencer: Moore control FSM driving DataPath strobes for fetch, ld, ldi, st, nop and halt.
// Latency: T0..END spans ld/st 9+2W, ldi 7+W, nop 5+W cycles (W = MEM_WAIT); outputs decode from state.
// Backpressure: none; each memory access stretches by MEM_WAIT cycles. Build option: UNDEF_TRAP_EN.
module ldst_control_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        ADD,
    output logic        Read,
    output logic        Write,
`ifdef UNDEF_TRAP_EN
    output logic        Illegal,
`endif
    output logic        Run
);

    typedef enum logic [4:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3,
        S_LD3, S_LD4, S_LD5, S_LD6, S_LD7,
        S_LDI3, S_LDI4, S_LDI5,
        S_ST3, S_ST4, S_ST5, S_ST6, S_ST7,
        S_END, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state;
    logic [2:0] wait_cnt;
    logic [4:0] opcode;
    logic       wait_done;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign unused_ir = ^IR[26:0];

`ifdef UNDEF_TRAP_EN
    logic illegal_q;
    assign Illegal = illegal_q;
`endif

    // State and wait-counter update. The counter is cleared on every state change so each
    // memory state starts counting from 0. Memory-class opcodes branch straight out of T2;
    // only the remaining opcodes spend a cycle in T3 for their decode.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_RST;
            wait_cnt <= '0;
`ifdef UNDEF_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            wait_cnt <= '0;
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    if (wait_done) state <= S_T2;
                    else           wait_cnt <= wait_cnt + 3'd1;
                end
                S_T2: begin
                    case (opcode)
                        OP_LD:   state <= S_LD3;
                        OP_LDI:  state <= S_LDI3;
                        OP_ST:   state <= S_ST3;
                        default: state <= S_T3;
                    endcase
                end
                S_T3: begin
                    case (opcode)
                        OP_HALT: state <= S_HALT;
                        OP_NOP:  state <= S_END;
                        default: begin
`ifdef UNDEF_TRAP_EN
                            state     <= S_HALT;
                            illegal_q <= 1'b1;
`else
                            state <= S_END;
`endif
                        end
                    endcase
                end
                S_LD3:  state <= S_LD4;
                S_LD4:  state <= S_LD5;
                S_LD5:  state <= S_LD6;
                S_LD6: begin
                    if (wait_done) state <= S_LD7;
                    else           wait_cnt <= wait_cnt + 3'd1;
                end
                S_LD7:  state <= S_END;
                S_LDI3: state <= S_LDI4;
                S_LDI4: state <= S_LDI5;
                S_LDI5: state <= S_END;
                S_ST3:  state <= S_ST4;
                S_ST4:  state <= S_ST5;
                S_ST5:  state <= S_ST6;
                S_ST6:  state <= S_ST7;
                S_ST7: begin
                    if (wait_done) state <= S_END;
                    else           wait_cnt <= wait_cnt + 3'd1;
                end
                S_END:  state <= Stop ? S_HALT : S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Strobe decode from state (and wait count for the stretched memory states).
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zlowin = 1'b0; Zhighin = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0; ADD = 1'b0;
        Read = 1'b0; Write = 1'b0;
        Run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            end
            S_T1: begin
                Read = 1'b1;
                if (wait_done) begin
                    Zlowout = 1'b1; PCin = 1'b1; MDRin = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_LD3, S_LDI3, S_ST3: begin
                Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end
            S_LD4, S_LDI4, S_ST4: begin
                Cout = 1'b1; ADD = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
            end
            S_LD5, S_ST5: begin
                Zlowout = 1'b1; MARin = 1'b1;
            end
            S_LD6: begin
                Read  = 1'b1;
                MDRin = wait_done;
            end
            S_LD7: begin
                MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            S_LDI5: begin
                Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            S_ST6: begin
                Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end
            S_ST7: begin
                Write = 1'b1;
            end
            default: begin
                Run = Run;
            end
        endcase
    end

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// tb_ldst_control_sequencer: directed vector bench for the ld/ldi/st control sequencer.
// Two instances: MEM_WAIT=0 for the main sequences, MEM_WAIT=2 for the stretched memory accesses.
// Each record holds the strobe pattern expected in a cycle and the IR/Stop presented during it.
module tb_ldst_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, clear2;
    logic [31:0] ir, ir2;
    logic        stop, stop2;
    logic [21:0] o0, o2;
`ifdef UNDEF_TRAP_EN
    logic        illegal0, illegal2;
`endif

    always #5 clock = ~clock;

    // Output vector layout: {PCout,Zlowout,MDRout,Cout,BAout,Rout,MARin,PCin,MDRin,IRin,Yin,
    //                        Zlowin,Zhighin,Rin,Gra,Grb,Grc,IncPC,ADD,Read,Write,Run}
    localparam logic [21:0] B_PCOUT   = 22'(1) << 21;
    localparam logic [21:0] B_ZLOWOUT = 22'(1) << 20;
    localparam logic [21:0] B_MDROUT  = 22'(1) << 19;
    localparam logic [21:0] B_COUT    = 22'(1) << 18;
    localparam logic [21:0] B_BAOUT   = 22'(1) << 17;
    localparam logic [21:0] B_ROUT    = 22'(1) << 16;
    localparam logic [21:0] B_MARIN   = 22'(1) << 15;
    localparam logic [21:0] B_PCIN    = 22'(1) << 14;
    localparam logic [21:0] B_MDRIN   = 22'(1) << 13;
    localparam logic [21:0] B_IRIN    = 22'(1) << 12;
    localparam logic [21:0] B_YIN     = 22'(1) << 11;
    localparam logic [21:0] B_ZLOWIN  = 22'(1) << 10;
    localparam logic [21:0] B_ZHIGHIN = 22'(1) << 9;
    localparam logic [21:0] B_RIN     = 22'(1) << 8;
    localparam logic [21:0] B_GRA     = 22'(1) << 7;
    localparam logic [21:0] B_GRB     = 22'(1) << 6;
    localparam logic [21:0] B_INCPC   = 22'(1) << 4;
    localparam logic [21:0] B_ADD     = 22'(1) << 3;
    localparam logic [21:0] B_READ    = 22'(1) << 2;
    localparam logic [21:0] B_WRITE   = 22'(1) << 1;
    localparam logic [21:0] B_RUN     = 22'(1);

    localparam logic [21:0] E_OFF  = 22'd0;
    localparam logic [21:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_RUN;
    localparam logic [21:0] E_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [21:0] E_RDW  = B_READ | B_RUN;
    localparam logic [21:0] E_T2   = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [21:0] E_IDLE = B_RUN;
    localparam logic [21:0] E_X3   = B_GRB | B_BAOUT | B_YIN | B_RUN;
    localparam logic [21:0] E_X4   = B_COUT | B_ADD | B_ZLOWIN | B_ZHIGHIN | B_RUN;
    localparam logic [21:0] E_X5   = B_ZLOWOUT | B_MARIN | B_RUN;
    localparam logic [21:0] E_LD6  = B_READ | B_MDRIN | B_RUN;
    localparam logic [21:0] E_LD7  = B_MDROUT | B_GRA | B_RIN | B_RUN;
    localparam logic [21:0] E_LDI5 = B_ZLOWOUT | B_GRA | B_RIN | B_RUN;
    localparam logic [21:0] E_ST6  = B_GRA | B_ROUT | B_MDRIN | B_RUN;
    localparam logic [21:0] E_ST7  = B_WRITE | B_RUN;

    localparam logic [31:0] IR_LD   = 32'h0090_0054;
    localparam logic [31:0] IR_LDI  = 32'h0890_0054;
    localparam logic [31:0] IR_ST   = 32'h1090_0054;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_UND  = 32'hF800_0000;

    typedef struct {
        logic [31:0] ir;
        logic        stop;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ldst_control_sequencer #(.MEM_WAIT(0)) dut0 (
        .clock(clock), .clear(clear), .IR(ir), .Stop(stop),
        .PCout(o0[21]), .Zlowout(o0[20]), .MDRout(o0[19]), .Cout(o0[18]), .BAout(o0[17]),
        .Rout(o0[16]), .MARin(o0[15]), .PCin(o0[14]), .MDRin(o0[13]), .IRin(o0[12]),
        .Yin(o0[11]), .Zlowin(o0[10]), .Zhighin(o0[9]), .Rin(o0[8]), .Gra(o0[7]),
        .Grb(o0[6]), .Grc(o0[5]), .IncPC(o0[4]), .ADD(o0[3]), .Read(o0[2]), .Write(o0[1]),
`ifdef UNDEF_TRAP_EN
        .Illegal(illegal0),
`endif
        .Run(o0[0])
    );

    ldst_control_sequencer #(.MEM_WAIT(2)) dut2 (
        .clock(clock), .clear(clear2), .IR(ir2), .Stop(stop2),
        .PCout(o2[21]), .Zlowout(o2[20]), .MDRout(o2[19]), .Cout(o2[18]), .BAout(o2[17]),
        .Rout(o2[16]), .MARin(o2[15]), .PCin(o2[14]), .MDRin(o2[13]), .IRin(o2[12]),
        .Yin(o2[11]), .Zlowin(o2[10]), .Zhighin(o2[9]), .Rin(o2[8]), .Gra(o2[7]),
        .Grb(o2[6]), .Grc(o2[5]), .IncPC(o2[4]), .ADD(o2[3]), .Read(o2[2]), .Write(o2[1]),
`ifdef UNDEF_TRAP_EN
        .Illegal(illegal2),
`endif
        .Run(o2[0])
    );

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] i, input logic s, input logic [21:0] e);
        vec_t v;
        v.ir = i; v.stop = s; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic add_fetch(input logic [31:0] i, input logic s);
        add(i, s, E_T0); add(i, s, E_T1); add(i, s, E_T2);
    endtask

    task automatic add_ld(input logic [31:0] i, input logic s_late);
        add_fetch(i, 1'b0);
        add(i, 1'b0, E_X3); add(i, 1'b0, E_X4);
        add(i, s_late, E_X5); add(i, s_late, E_LD6); add(i, s_late, E_LD7);
        add(i, s_late, E_IDLE);
    endtask

    // Walk table entries [lo,hi): after each rising edge check the state's strobes,
    // then present that record's IR/Stop for the following edge.
    task automatic run(input int which, input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s[%0d]", tag, i - lo), (which == 0) ? o0 : o2, tbl[i].exp);
            if (which == 0) begin
                ir = tbl[i].ir; stop = tbl[i].stop;
            end else begin
                ir2 = tbl[i].ir; stop2 = tbl[i].stop;
            end
        end
    endtask

    task automatic clear_pulse(input string tag);
        clear = 1'b0;
        #1;
        check({tag, "_async"}, o0, E_OFF);
        @(posedge clock);
        #1;
        check({tag, "_held"}, o0, E_OFF);
        clear = 1'b1;
    endtask

    initial begin
        int a_lo, a_hi, b_hi, c_hi, d_hi, e_hi, f_hi;
        clear = 1'b0; clear2 = 1'b0;
        ir = '0; ir2 = '0; stop = 1'b0; stop2 = 1'b0;

        // A: ld, ldi, st, nop, nop with early Stop, ld with late Stop into HALT
        a_lo = 0;
        add_ld(IR_LD, 1'b0);
        add_fetch(IR_LDI, 1'b0);
        add(IR_LDI, 1'b0, E_X3); add(IR_LDI, 1'b0, E_X4); add(IR_LDI, 1'b0, E_LDI5);
        add(IR_LDI, 1'b0, E_IDLE);
        add_fetch(IR_ST, 1'b0);
        add(IR_ST, 1'b0, E_X3); add(IR_ST, 1'b0, E_X4); add(IR_ST, 1'b0, E_X5);
        add(IR_ST, 1'b0, E_ST6); add(IR_ST, 1'b0, E_ST7); add(IR_ST, 1'b0, E_IDLE);
        add_fetch(IR_NOP, 1'b0); add(IR_NOP, 1'b0, E_IDLE); add(IR_NOP, 1'b0, E_IDLE);
        add_fetch(IR_NOP, 1'b1); add(IR_NOP, 1'b0, E_IDLE); add(IR_NOP, 1'b0, E_IDLE);
        add_ld(IR_LD, 1'b1);
        add(IR_LD, 1'b0, E_OFF); add(IR_LD, 1'b1, E_OFF); add(IR_LD, 1'b0, E_OFF);
        a_hi = tbl.size();
        // B: halt instruction
        add_fetch(IR_HALT, 1'b0); add(IR_HALT, 1'b0, E_IDLE);
        add(IR_HALT, 1'b0, E_OFF); add(IR_HALT, 1'b0, E_OFF);
        b_hi = tbl.size();
        // C: unrecognised opcode
        add_fetch(IR_UND, 1'b0); add(IR_UND, 1'b0, E_IDLE);
`ifdef UNDEF_TRAP_EN
        add(IR_UND, 1'b0, E_OFF); add(IR_UND, 1'b0, E_OFF);
`else
        add(IR_UND, 1'b0, E_IDLE); add(IR_UND, 1'b0, E_T0);
`endif
        c_hi = tbl.size();
        // D: ld up to LD6, then aborted by clear
        add_fetch(IR_LD, 1'b0);
        add(IR_LD, 1'b0, E_X3); add(IR_LD, 1'b0, E_X4); add(IR_LD, 1'b0, E_X5);
        add(IR_LD, 1'b0, E_LD6);
        d_hi = tbl.size();
        // E: full ld after the abort, then next fetch
        add_ld(IR_LD, 1'b0); add(IR_NOP, 1'b0, E_T0);
        e_hi = tbl.size();
        // F: MEM_WAIT=2 st then ld
        add(IR_ST, 1'b0, E_T0);
        add(IR_ST, 1'b0, E_RDW); add(IR_ST, 1'b0, E_RDW); add(IR_ST, 1'b0, E_T1);
        add(IR_ST, 1'b0, E_T2); add(IR_ST, 1'b0, E_X3); add(IR_ST, 1'b0, E_X4);
        add(IR_ST, 1'b0, E_X5); add(IR_ST, 1'b0, E_ST6);
        add(IR_ST, 1'b0, E_ST7); add(IR_ST, 1'b0, E_ST7); add(IR_ST, 1'b0, E_ST7);
        add(IR_ST, 1'b0, E_IDLE);
        add(IR_LD, 1'b0, E_T0);
        add(IR_LD, 1'b0, E_RDW); add(IR_LD, 1'b0, E_RDW); add(IR_LD, 1'b0, E_T1);
        add(IR_LD, 1'b0, E_T2); add(IR_LD, 1'b0, E_X3); add(IR_LD, 1'b0, E_X4);
        add(IR_LD, 1'b0, E_X5);
        add(IR_LD, 1'b0, E_RDW); add(IR_LD, 1'b0, E_RDW); add(IR_LD, 1'b0, E_LD6);
        add(IR_LD, 1'b0, E_LD7); add(IR_LD, 1'b0, E_IDLE); add(IR_LD, 1'b0, E_T0);
        f_hi = tbl.size();

        #2;
        check("reset0", o0, E_OFF);
        check("reset2", o2, E_OFF);
        @(posedge clock);
        #1;
        check("reset0_held", o0, E_OFF);
        clear = 1'b1;

        run(0, a_lo, a_hi, "A");
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("halt_hold[%0d]", i), o0, E_OFF);
            stop = i[0];
        end
        stop = 1'b0;
        clear_pulse("clrB");
        run(0, a_hi, b_hi, "B");
        clear_pulse("clrC");
        run(0, b_hi, c_hi, "C");
`ifdef UNDEF_TRAP_EN
        n_checks++;
        if (illegal0 !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_set: got %b expected 1", illegal0);
        end
`endif
        clear_pulse("clrD");
`ifdef UNDEF_TRAP_EN
        n_checks++;
        if (illegal0 !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clr: got %b expected 0", illegal0);
        end
`endif
        run(0, c_hi, d_hi, "D");
        #2;
        clear = 1'b0;
        #1;
        check("abort_ld6_async", o0, E_OFF);
        @(posedge clock);
        #1;
        check("abort_ld6_held", o0, E_OFF);
        clear = 1'b1;
        run(0, d_hi, e_hi, "E");

        check("w2_idle", o2, E_OFF);
        clear2 = 1'b1;
        run(2, e_hi, f_hi, "F");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
